// File: rtl/alu_shift_wb_queue.sv
// Writeback skid queue behind the shift ALU: a circular buffer of shift results
// with per-thread kill on exception, auto-drain of killed slots and head parity check.
module alu_shift_wb_queue #(
   parameter  int DEPTH     = 4,
   parameter  int REG_WIDTH = 5,
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 except,
   input  logic                 except_thread,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [65:0]          in_res,
   input  logic [5:0]           in_flags,
   input  logic [REG_WIDTH-1:0] in_tag,
   input  logic                 in_thread,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [65:0]          out_res,
   output logic [5:0]           out_flags,
   output logic [REG_WIDTH-1:0] out_tag,
   output logic                 out_thread,
   output logic                 out_perr,
   output logic [PTR_W:0]       count
);

   // Handshake: a transfer happens on a posedge where valid and ready are both
   // high; in_rdy depends on count only, out_vld never depends on out_rdy.

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [DEPTH-1:0]     live_q, live_d;

   logic [65:0]          res_q    [DEPTH];
   logic [5:0]           flags_q  [DEPTH];
   logic [REG_WIDTH-1:0] tag_q    [DEPTH];
   logic [DEPTH-1:0]     thread_q;

   logic nonempty, head_live, push, pop, drain, retire, flush_in;

   always_comb begin
      nonempty  = (count_q != '0);
      head_live = live_q[head_q];
      in_rdy    = (count_q != CNT_FULL);
      // Same-thread pushes racing a flush belong to the squashed path.
      flush_in  = except & (in_thread == except_thread);
      push      = in_vld & in_rdy & ~flush_in;
      out_vld   = head_live & nonempty;
      pop       = out_vld & out_rdy;
      drain     = nonempty & ~head_live;
      retire    = pop | drain;
   end

   always_comb begin
      head_d  = retire ? head_q + PTR_ONE : head_q;
      tail_d  = push   ? tail_q + PTR_ONE : tail_q;
      count_d = count_q;
      unique case ({push, retire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Order matters: retire clear, then flush kill, then the fresh push sets live.
   always_comb begin
      live_d = live_q;
      if (retire) live_d[head_q] = 1'b0;
      if (except) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (thread_q[i] == except_thread) live_d[i] = 1'b0;
         end
      end
      if (push) live_d[tail_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         live_q  <= live_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         res_q[tail_q]    <= in_res;
         flags_q[tail_q]  <= in_flags;
         tag_q[tail_q]    <= in_tag;
         thread_q[tail_q] <= in_thread;
      end
   end

   always_comb begin
      out_res    = res_q[head_q];
      out_flags  = flags_q[head_q];
      out_tag    = tag_q[head_q];
      out_thread = thread_q[head_q];
      out_perr   = out_vld & ((^out_res[64:0]) != out_res[65]);
      count      = count_q;
   end

endmodule

// File: tb/tb_alu_shift_wb_queue.sv
// Directed bench for alu_shift_wb_queue: hand-computed vectors plus a pop
// scoreboard holding the results expected on the writeback side, in order.
module tb_alu_shift_wb_queue;

   localparam int DEPTH = 4;
   localparam int REG_WIDTH = 5;
   localparam int PTR_W = $clog2(DEPTH);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 except = 1'b0;
   logic                 except_thread = 1'b0;
   logic                 in_vld = 1'b0;
   logic                 in_rdy;
   logic [65:0]          in_res = '0;
   logic [5:0]           in_flags = '0;
   logic [REG_WIDTH-1:0] in_tag = '0;
   logic                 in_thread = 1'b0;
   logic                 out_vld;
   logic                 out_rdy = 1'b0;
   logic [65:0]          out_res;
   logic [5:0]           out_flags;
   logic [REG_WIDTH-1:0] out_tag;
   logic                 out_thread;
   logic                 out_perr;
   logic [PTR_W:0]       count;

   int checks = 0;
   int errors = 0;
   logic [65:0] exp_q[$];

   alu_shift_wb_queue #(.DEPTH(DEPTH), .REG_WIDTH(REG_WIDTH)) dut (
      .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_res(in_res), .in_flags(in_flags),
      .in_tag(in_tag), .in_thread(in_thread), .out_vld(out_vld), .out_rdy(out_rdy),
      .out_res(out_res), .out_flags(out_flags), .out_tag(out_tag),
      .out_thread(out_thread), .out_perr(out_perr), .count(count)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Good parity: bit64 = 0, bit65 = xor of data.
   function automatic logic [65:0] mk(input logic [63:0] d);
      mk = {^d, 1'b0, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [65:0] r, input logic th, input bit expect_pop);
      in_vld    = 1'b1;
      in_res    = r;
      in_thread = th;
      in_flags  = r[5:0];
      in_tag    = r[4:0];
      if (expect_pop) exp_q.push_back(r);
      step();
      in_vld = 1'b0;
   endtask

   // scoreboard: every accepted pop must match the head of exp_q
   always @(negedge clk) begin
      if (rst && out_vld && out_rdy) begin
         if (exp_q.size() == 0) chk("pop_unexpected", out_res, '0);
         else chk("pop_res", out_res, exp_q.pop_front());
      end
   end

   initial begin
      // reset
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_in_rdy", in_rdy, 1);
      chk("rst_perr", out_perr, 0);

      // basic push then pop in order
      push(mk(64'h1), 1'b0, 1);
      chk("lat_out_vld", out_vld, 1);
      push(mk(64'h2), 1'b0, 1);
      push(mk(64'h3), 1'b0, 1);
      chk("t1_count", count, 3);
      chk("t1_out_vld", out_vld, 1);
      chk("t1_head", out_res, mk(64'h1));
      out_rdy = 1'b1;
      step(); step(); step();
      chk("t1_count_end", count, 0);
      chk("t1_vld_end", out_vld, 0);
      out_rdy = 1'b0;

      // full, ignored push, push+pop at count 2
      for (int i = 0; i < 4; i++) push(mk(64'h10 + 64'(i)), 1'b0, 1);
      chk("t2_count_full", count, 4);
      chk("t2_in_rdy_full", in_rdy, 0);
      push(mk(64'h99), 1'b0, 0);
      chk("t2_count_ovf", count, 4);
      chk("t2_head_ovf", out_res, mk(64'h10));
      out_rdy = 1'b1;
      step(); step();
      chk("t2_count_2", count, 2);
      push(mk(64'h14), 1'b0, 1);
      chk("t2_count_pp", count, 2);
      step(); step();
      chk("t2_count_end", count, 0);
      chk("t2_vld_end", out_vld, 0);
      out_rdy = 1'b0;

      // flush thread 0 out of {0,1,0,1}
      push(mk(64'h20), 1'b0, 0);
      push(mk(64'h21), 1'b1, 1);
      push(mk(64'h22), 1'b0, 0);
      push(mk(64'h23), 1'b1, 1);
      except = 1'b1; except_thread = 1'b0;
      step();
      except = 1'b0;
      chk("t3_count_4", count, 4);
      chk("t3_vld_killed", out_vld, 0);
      step();
      chk("t3_count_3", count, 3);
      chk("t3_vld_live", out_vld, 1);
      chk("t3_head_21", out_res, mk(64'h21));
      out_rdy = 1'b1;
      step();
      chk("t3_count_2", count, 2);
      chk("t3_vld_killed2", out_vld, 0);
      step();
      chk("t3_count_1", count, 1);
      chk("t3_head_23", out_res, mk(64'h23));
      step();
      chk("t3_count_0", count, 0);
      out_rdy = 1'b0;

      // flush racing incoming pushes
      except = 1'b1; except_thread = 1'b1;
      push(mk(64'h30), 1'b1, 0);
      chk("t4_drop", count, 0);
      push(mk(64'h31), 1'b0, 1);
      except = 1'b0;
      chk("t4_keep", count, 1);
      chk("t4_vld", out_vld, 1);
      chk("t4_thread", out_thread, 0);
      out_rdy = 1'b1;
      step();
      chk("t4_count_end", count, 0);
      out_rdy = 1'b0;

      // parity
      push(66'h1, 1'b0, 1);
      chk("t5_perr_bad", out_perr, 1);
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      push(mk(64'h1), 1'b0, 1);
      chk("t5_perr_good", out_perr, 0);
      out_rdy = 1'b1;
      step();
      chk("t5_count_end", count, 0);
      out_rdy = 1'b0;

      // reset wins over a pending pop
      push(mk(64'h40), 1'b0, 0);
      push(mk(64'h41), 1'b0, 0);
      push(mk(64'h42), 1'b0, 0);
      out_rdy = 1'b1;
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t6_rst_count", count, 0);
      chk("t6_rst_vld", out_vld, 0);
      chk("t6_rst_in_rdy", in_rdy, 1);

      // wrap: 9 streaming push/pop cycles
      for (int i = 0; i < 9; i++) push(mk(64'h50 + 64'(i)), 1'b0, 1);
      chk("t6_stream_count", count, 1);
      step();
      chk("t6_wrap_count", count, 0);
      out_rdy = 1'b0;
      step();
      chk("sb_empty", 66'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
